// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: widths, operand and
// product types, and the control state encoding.
package booth_multiplier_pkg;

  // Magnitude width; operands carry one extra sign bit.
  localparam int unsigned DW = 8;

  // Width of the step counter (counts 0 .. DW).
  localparam int unsigned CW = $clog2(DW + 1);

  typedef logic signed [DW:0] operand_t;
  typedef logic [2*DW+1:0]    prod_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth step: conditionally add or subtract M into the
// accumulator based on {Q[0], q_1}, then arithmetic-shift {A, Q, q_1} right
// by one bit.
module booth_multiplier_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW+1:0] a,
  input  logic [DW:0]   q,
  input  logic          q_1,
  input  logic [DW+1:0] m,
  output logic [DW+1:0] a_next,
  output logic [DW:0]   q_next,
  output logic          q_1_next
);

  logic [DW+1:0] sum;

  // Booth recoding of the current bit pair, followed by the right shift.
  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      2'b01:   sum = a + m;
      2'b10:   sum = a - m;
      default: sum = a;
    endcase
    a_next   = {sum[DW+1], sum[DW+1:1]};
    q_next   = {sum[0], q[DW:1]};
    q_1_next = q[0];
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier. Accepts two signed DW+1 bit operands
// on start, performs one Booth step per clock for DW+1 clocks and presents
// the signed 2*DW+2 bit product with a one-cycle done pulse.
module booth_multiplier #(
  parameter int unsigned DW = booth_multiplier_pkg::DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW:0]     multiplier,
  input  logic [DW:0]     multiplicand,
  output logic [2*DW+1:0] product,
  output logic            done,
  output logic            busy
);

  import booth_multiplier_pkg::*;

  localparam int unsigned CNT_W = $clog2(DW + 1);

  state_t           state;
  logic [DW+1:0]    a;
  logic [DW:0]      q;
  logic             q_1;
  logic [DW+1:0]    m;
  logic [CNT_W-1:0] count;

  logic [DW+1:0]    a_next;
  logic [DW:0]      q_next;
  logic             q_1_next;

  booth_multiplier_step #(
    .DW (DW)
  ) booth_step (
    .a        (a),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .a_next   (a_next),
    .q_next   (q_next),
    .q_1_next (q_1_next)
  );

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      a       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      m       <= '0;
      count   <= '0;
      product <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            a     <= '0;
            q     <= multiplier;
            q_1   <= 1'b0;
            // One extra sign bit keeps A - M from overflowing for M = -2^DW.
            m     <= {multiplicand[DW], multiplicand};
            count <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          a     <= a_next;
          q     <= q_next;
          q_1   <= q_1_next;
          count <= count + CNT_W'(1);
          if (count == CNT_W'(DW)) begin
            // Product is taken from the post-step value of {A, Q}.
            product <= {a_next[DW:0], q_next};
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
